// File: rtl/fifo16_pixel_streamer_if.sv
// Pixel output stream of fifo16_pixel_streamer: valid/ready handshake with
// RGB565 data and line/frame position flags.
interface fifo16_pixel_streamer_if;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_data;
   logic        pix_sol;
   logic        pix_eol;
   logic        pix_sof;
   logic        pix_eof;

   modport master (
      output pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof,
      input  pix_ready
   );

   modport slave (
      input  pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof,
      output pix_ready
   );
endinterface

// File: rtl/fifo16_pixel_streamer.sv
// Read-side consumer of the prefetch FIFO: pops RGB565 words, tags frame position,
// one registered output stage. FIFO16_PIXSTREAM_UNDERRUN_CNT_EN adds underrun_cnt.
module fifo16_pixel_streamer #(
   parameter int H_PIX   = 640,
   parameter int V_LINES = 480,
   parameter int XW      = 10,
   parameter int YW      = 9
) (
   input  logic                            rd_clk,
   input  logic                            rd_rst_n,
   input  logic                            start,
   input  logic                            stop,
   output logic                            fifo_rd_en,
   input  logic                            fifo_rd_vld,
   input  logic [15:0]                     fifo_rd_data,
   fifo16_pixel_streamer_if.master         pix,
   output logic                            busy,
   output logic                            frame_done
`ifdef FIFO16_PIXSTREAM_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                     underrun_cnt
`endif
);

   localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          valid_q, valid_d;
   logic [15:0]   data_q, data_d;
   logic          sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;

   logic accept;
   logic start_ok;
   logic last_pix;

   assign accept   = valid_q & pix.pix_ready;
   assign start_ok = (state_q == IDLE) & start & ~stop;
   assign last_pix = (x_q == X_LAST) & (y_q == Y_LAST);

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // stop outranks every other event, including a simultaneous start in IDLE
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fifo_rd_en && last_pix) state_d = DRAIN;
            DRAIN:   if (accept) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state_q != IDLE);
      fifo_rd_en = (state_q == RUN) & fifo_rd_vld & (~valid_q | pix.pix_ready) & ~stop;
      frame_done = (state_q == DRAIN) & accept & ~stop;
   end

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      data_d  = data_q;
      sol_d   = sol_q;
      eol_d   = eol_q;
      sof_d   = sof_q;
      eof_d   = eof_q;
      valid_d = valid_q;
      if (start_ok) begin
         x_d = '0;
         y_d = '0;
      end
      // flags describe the position of the word being popped, before x/y advance
      if (fifo_rd_en) begin
         data_d = fifo_rd_data;
         sol_d  = (x_q == '0);
         eol_d  = (x_q == X_LAST);
         sof_d  = (x_q == '0) & (y_q == '0);
         eof_d  = last_pix;
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
      if (stop) begin
         valid_d = 1'b0;
      end else if (fifo_rd_en) begin
         valid_d = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         sol_q   <= 1'b0;
         eol_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sol_q   <= sol_d;
         eol_q   <= eol_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
      end
   end

   assign pix.pix_valid = valid_q;
   assign pix.pix_data  = data_q;
   assign pix.pix_sol   = sol_q;
   assign pix.pix_eol   = eol_q;
   assign pix.pix_sof   = sof_q;
   assign pix.pix_eof   = eof_q;

`ifdef FIFO16_PIXSTREAM_UNDERRUN_CNT_EN
   logic [15:0] urun_q, urun_d;

   // a starved cycle: the output stage could take a word but the FIFO has none
   always_comb begin
      urun_d = urun_q;
      if (start_ok) begin
         urun_d = '0;
      end else if ((state_q == RUN) && (!valid_q || pix.pix_ready) && !fifo_rd_vld
                   && (urun_q != 16'hFFFF)) begin
         urun_d = urun_q + 16'd1;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         urun_q <= '0;
      end else begin
         urun_q <= urun_d;
      end
   end

   assign underrun_cnt = urun_q;
`endif

endmodule
